// File: rtl/oldland_pkg.sv
// Shared instruction encodings, field positions and decoded-record type for the oldland decode pipe.
// The OLDLAND_DECODE_ILLEGAL_EN macro adds the illegal-instruction flag and its legality tables.
package oldland_pkg;

  typedef enum logic [1:0] {
    CLASS_ARITH  = 2'b00,
    CLASS_BRANCH = 2'b01,
    CLASS_MEM    = 2'b10,
    CLASS_MISC   = 2'b11
  } instr_class_t;

  localparam logic [3:0] OPCODE_ADD   = 4'b0000;
  localparam logic [3:0] OPCODE_ADDC  = 4'b0001;
  localparam logic [3:0] OPCODE_CMP   = 4'b0010;
  localparam logic [3:0] OPCODE_AND   = 4'b0011;
  localparam logic [3:0] OPCODE_LSL   = 4'b0100;
  localparam logic [3:0] OPCODE_LSR   = 4'b0101;
  localparam logic [3:0] OPCODE_MOVHI = 4'b0110;
  localparam logic [3:0] OPCODE_OR    = 4'b0111;
  localparam logic [3:0] OPCODE_SUB   = 4'b1000;
  localparam logic [3:0] OPCODE_SUBC  = 4'b1001;
  localparam logic [3:0] OPCODE_XOR   = 4'b1010;
  localparam logic [3:0] OPCODE_ASR   = 4'b1011;

  localparam logic [3:0] OPCODE_CALL  = 4'b0000;
  localparam logic [3:0] OPCODE_RET   = 4'b0001;
  localparam logic [3:0] OPCODE_B     = 4'b0100;
  localparam logic [3:0] OPCODE_BNE   = 4'b1001;
  localparam logic [3:0] OPCODE_BEQ   = 4'b1010;
  localparam logic [3:0] OPCODE_BGT   = 4'b1011;
  localparam logic [3:0] OPCODE_BLT   = 4'b1100;

  localparam logic [3:0] OPCODE_LDR32 = 4'b0000;
  localparam logic [3:0] OPCODE_LDR16 = 4'b0001;
  localparam logic [3:0] OPCODE_LDR8  = 4'b0010;
  localparam logic [3:0] OPCODE_STR32 = 4'b0100;
  localparam logic [3:0] OPCODE_STR16 = 4'b0101;
  localparam logic [3:0] OPCODE_STR8  = 4'b0110;

  localparam logic [3:0] OPCODE_SWI   = 4'b0000;
  localparam logic [3:0] OPCODE_RFE   = 4'b0001;
  localparam logic [3:0] OPCODE_GCR   = 4'b0010;
  localparam logic [3:0] OPCODE_SCR   = 4'b0011;
  localparam logic [3:0] OPCODE_BKP   = 4'b0100;
  localparam logic [3:0] OPCODE_CACHE = 4'b0101;

  typedef enum logic [2:0] {
    COND_NONE   = 3'd0,
    COND_NE     = 3'd1,
    COND_EQ     = 3'd2,
    COND_GT     = 3'd3,
    COND_LT     = 3'd4,
    COND_ALWAYS = 3'd7
  } branch_cond_t;

  localparam int CLASS_MSB  = 31;
  localparam int CLASS_LSB  = 30;
  localparam int OPC_MSB    = 29;
  localparam int OPC_LSB    = 26;
  localparam int IMM16_MSB  = 25;
  localparam int IMM16_LSB  = 10;
  localparam int IMM24_MSB  = 23;
  localparam int REG_IND    = 25;
  localparam int RB_USE     = 9;
  localparam int RD_MSB     = 8;
  localparam int RD_LSB     = 6;
  localparam int RA_MSB     = 5;
  localparam int RA_LSB     = 3;
  localparam int RB_MSB     = 2;
  localparam int STORE_BIT  = 2;

  typedef struct packed {
    logic [2:0]  rd_sel;
    logic        update_rd;
    logic [31:0] imm32;
    logic [3:0]  alu_opc;
    logic [2:0]  branch_condition;
    logic        alu_op1_ra;
    logic        alu_op2_rb;
    logic        mem_load;
    logic        mem_store;
    logic        branch_ra;
    logic        is_call;
    logic [1:0]  instr_class;
`ifdef OLDLAND_DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } decoded_t;

  function automatic logic [2:0] branch_cond(input logic [3:0] opc);
    case (opc)
      OPCODE_BNE: return COND_NE;
      OPCODE_BEQ: return COND_EQ;
      OPCODE_BGT: return COND_GT;
      OPCODE_BLT: return COND_LT;
      default:    return COND_ALWAYS;
    endcase
  endfunction

`ifdef OLDLAND_DECODE_ILLEGAL_EN
  function automatic logic branch_legal(input logic [3:0] opc);
    return opc inside {OPCODE_BNE, OPCODE_BEQ, OPCODE_BGT, OPCODE_BLT,
                       OPCODE_B, OPCODE_CALL, OPCODE_RET};
  endfunction

  function automatic logic misc_legal(input logic [3:0] opc);
    return opc inside {OPCODE_SWI, OPCODE_RFE, OPCODE_GCR, OPCODE_SCR,
                       OPCODE_BKP, OPCODE_CACHE};
  endfunction
`endif

endpackage

// File: rtl/oldland_decode_fields.sv
// Purely combinational instruction-to-fields decoder for the oldland decode pipe.
// With OLDLAND_DECODE_ILLEGAL_EN it also flags undefined MISC/BRANCH opcodes.
module oldland_decode_fields
  import oldland_pkg::*;
#(
  parameter logic [2:0] LINK_REG = 3'd6
) (
  input  logic [31:0] instr,
  output logic [2:0]  ra_sel,
  output logic [2:0]  rb_sel,
  output logic        ra_used,
  output logic        rb_used,
  output decoded_t    fields
);

  instr_class_t cls;
  logic [3:0]   opc;
  logic         is_ret;

  assign cls    = instr_class_t'(instr[CLASS_MSB:CLASS_LSB]);
  assign opc    = instr[OPC_MSB:OPC_LSB];
  assign is_ret = (cls == CLASS_BRANCH) && (opc == OPCODE_RET);
  assign ra_sel = is_ret ? LINK_REG : instr[RA_MSB:RA_LSB];
  assign rb_sel = instr[RB_MSB:0];

  always_comb begin
    fields             = '0;
    ra_used            = 1'b0;
    rb_used            = 1'b0;
    fields.rd_sel      = instr[RD_MSB:RD_LSB];
    fields.instr_class = instr[CLASS_MSB:CLASS_LSB];

    if (cls == CLASS_BRANCH)
      fields.imm32 = {{6{instr[IMM24_MSB]}}, instr[IMM24_MSB:0], 2'b00};
    else if (cls == CLASS_ARITH && opc == OPCODE_MOVHI)
      fields.imm32 = {instr[IMM16_MSB:IMM16_LSB], 16'h0};
    else
      fields.imm32 = {{16{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB]};

    case (cls)
      CLASS_ARITH: begin
        fields.update_rd  = (opc != OPCODE_CMP);
        fields.alu_opc    = opc;
        fields.alu_op1_ra = 1'b1;
        fields.alu_op2_rb = instr[RB_USE];
        ra_used           = 1'b1;
        rb_used           = instr[RB_USE];
      end
      CLASS_BRANCH: begin
        fields.branch_condition = branch_cond(opc);
        fields.branch_ra        = instr[REG_IND] | is_ret;
        fields.is_call          = (opc == OPCODE_CALL);
        ra_used                 = instr[REG_IND] | is_ret;
      end
      CLASS_MEM: begin
        fields.alu_op1_ra = 1'b1;
        fields.mem_load   = ~opc[STORE_BIT];
        fields.mem_store  = opc[STORE_BIT];
        ra_used           = 1'b1;
        rb_used           = opc[STORE_BIT];
      end
      default: ;
    endcase

`ifdef OLDLAND_DECODE_ILLEGAL_EN
    fields.illegal = ((cls == CLASS_MISC) && !misc_legal(opc)) ||
                     ((cls == CLASS_BRANCH) && !branch_legal(opc));
    if (fields.illegal) begin
      fields.update_rd = 1'b0;
      fields.mem_load  = 1'b0;
      fields.mem_store = 1'b0;
      fields.is_call   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/oldland_decode_pipe.sv
// Handshaked oldland decode stage with flush and load-use interlock; register selects stay combinational.
// Defining OLDLAND_DECODE_ILLEGAL_EN adds the registered illegal_instr output.
module oldland_decode_pipe
  import oldland_pkg::*;
#(
  parameter logic [2:0]  LINK_REG            = 3'd6,
  parameter bit          LOAD_USE_STALL      = 1'b1,
  parameter logic [31:0] RESET_VECTOR_PLUS_4 = 32'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus_4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  ra_sel,
  output logic [2:0]  rb_sel,
  output logic [2:0]  rd_sel,
  output logic        update_rd,
  output logic [31:0] imm32,
  output logic [3:0]  alu_opc,
  output logic [2:0]  branch_condition,
  output logic        alu_op1_ra,
  output logic        alu_op2_rb,
  output logic        mem_load,
  output logic        mem_store,
  output logic        branch_ra,
  output logic        is_call,
  output logic [1:0]  instr_class,
`ifdef OLDLAND_DECODE_ILLEGAL_EN
  output logic        illegal_instr,
`endif
  output logic [31:0] pc_plus_4_out
);

  decoded_t    dec;
  decoded_t    q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        ra_used;
  logic        rb_used;
  logic        adv;
  logic        hz;

  oldland_decode_fields #(.LINK_REG(LINK_REG)) u_fields (
    .instr   (instr),
    .ra_sel  (ra_sel),
    .rb_sel  (rb_sel),
    .ra_used (ra_used),
    .rb_used (rb_used),
    .fields  (dec)
  );

  // A held load whose destination feeds the incoming instruction must leave before it is accepted.
  assign adv = !valid_q || out_ready;
  assign hz  = LOAD_USE_STALL && in_valid && valid_q && q.mem_load &&
               ((ra_used && (q.rd_sel == ra_sel)) || (rb_used && (q.rd_sel == rb_sel)));
  assign in_ready = adv && !hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      pc_q    <= RESET_VECTOR_PLUS_4;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      if (hz) begin
        valid_q <= 1'b0;
      end else if (in_valid) begin
        q       <= dec;
        pc_q    <= pc_plus_4;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Side-effecting controls are masked whenever the register holds no instruction.
  assign out_valid        = valid_q;
  assign rd_sel           = q.rd_sel;
  assign update_rd        = valid_q & q.update_rd;
  assign imm32            = q.imm32;
  assign alu_opc          = q.alu_opc;
  assign branch_condition = valid_q ? q.branch_condition : COND_NONE;
  assign alu_op1_ra       = q.alu_op1_ra;
  assign alu_op2_rb       = q.alu_op2_rb;
  assign mem_load         = valid_q & q.mem_load;
  assign mem_store        = valid_q & q.mem_store;
  assign branch_ra        = q.branch_ra;
  assign is_call          = valid_q & q.is_call;
  assign instr_class      = q.instr_class;
  assign pc_plus_4_out    = pc_q;
`ifdef OLDLAND_DECODE_ILLEGAL_EN
  assign illegal_instr    = valid_q & q.illegal;
`endif

endmodule

// File: tb/tb_oldland_decode_pipe.sv
// Scoreboard bench for oldland_decode_pipe: directed vectors push expected records, a monitor pops on each transfer.
// A second instance with LOAD_USE_STALL=0 shadows the same inputs to show the interlock can be disabled.
module tb_oldland_decode_pipe;

`ifdef OLDLAND_DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  rd;
    logic        upd;
    logic [31:0] imm;
    logic [3:0]  opc;
    logic [2:0]  cond;
    logic        op1;
    logic        op2;
    logic        ld;
    logic        st;
    logic        bra;
    logic        call;
    logic [1:0]  cls;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, flush, out_ready;
  logic [31:0] instr, pc_plus_4;
  logic        in_ready, out_valid, update_rd, alu_op1_ra, alu_op2_rb;
  logic        mem_load, mem_store, branch_ra, is_call;
  logic [2:0]  ra_sel, rb_sel, rd_sel, branch_condition;
  logic [31:0] imm32, pc_plus_4_out;
  logic [3:0]  alu_opc;
  logic [1:0]  instr_class;
  logic        ill_act;

  logic        ns_in_ready, ns_out_valid, ns_update_rd, ns_op1, ns_op2;
  logic        ns_ld, ns_st, ns_bra, ns_call;
  logic [2:0]  ns_ra, ns_rb, ns_rd, ns_cond;
  logic [31:0] ns_imm, ns_pc;
  logic [3:0]  ns_opc;
  logic [1:0]  ns_cls;

  exp_t sb[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   w;
  logic r;

  always #5 clk = ~clk;

`ifdef OLDLAND_DECODE_ILLEGAL_EN
  logic illegal_instr, ns_ill;
  assign ill_act = illegal_instr;
`else
  assign ill_act = 1'b0;
`endif

  oldland_decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_plus_4(pc_plus_4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel),
    .update_rd(update_rd), .imm32(imm32), .alu_opc(alu_opc),
    .branch_condition(branch_condition), .alu_op1_ra(alu_op1_ra),
    .alu_op2_rb(alu_op2_rb), .mem_load(mem_load), .mem_store(mem_store),
    .branch_ra(branch_ra), .is_call(is_call), .instr_class(instr_class),
`ifdef OLDLAND_DECODE_ILLEGAL_EN
    .illegal_instr(illegal_instr),
`endif
    .pc_plus_4_out(pc_plus_4_out)
  );

  oldland_decode_pipe #(.LOAD_USE_STALL(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready),
    .instr(instr), .pc_plus_4(pc_plus_4), .flush(flush),
    .out_valid(ns_out_valid), .out_ready(1'b1),
    .ra_sel(ns_ra), .rb_sel(ns_rb), .rd_sel(ns_rd),
    .update_rd(ns_update_rd), .imm32(ns_imm), .alu_opc(ns_opc),
    .branch_condition(ns_cond), .alu_op1_ra(ns_op1),
    .alu_op2_rb(ns_op2), .mem_load(ns_ld), .mem_store(ns_st),
    .branch_ra(ns_bra), .is_call(ns_call), .instr_class(ns_cls),
`ifdef OLDLAND_DECODE_ILLEGAL_EN
    .illegal_instr(ns_ill),
`endif
    .pc_plus_4_out(ns_pc)
  );

  function automatic exp_t mk(input logic [2:0] rd, input logic upd, input logic [31:0] imm,
                              input logic [3:0] opc, input logic [2:0] cond, input logic op1,
                              input logic op2, input logic ld, input logic st, input logic bra,
                              input logic call, input logic [1:0] cls, input logic [31:0] pc,
                              input logic ill);
    exp_t e;
    e = '{rd, upd, imm, opc, cond, op1, op2, ld, st, bra, call, cls, pc, ill};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Presents one word until it is accepted; the expected record is queued at the accepting edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                               input bit doFlush, output int waits, output logic nsReady0);
    logic acc;
    acc      = 1'b0;
    waits    = 0;
    nsReady0 = 1'b0;
    in_valid = 1'b1;
    instr    = ins;
    pc_plus_4 = pc;
    flush    = doFlush;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (k == 0) nsReady0 = ns_in_ready;
      if (acc && !doFlush) sb.push_back(e);
      @(posedge clk);
      #1;
      waits = k + 1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected acceptance of %0h", ins);
    end
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid)
        checkOutput("qualified_ctrl", {update_rd, mem_load, mem_store, is_call, branch_condition, ill_act}, '0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got pc_plus_4_out=%0h, expected no output", pc_plus_4_out);
        end else begin
          monExp = sb.pop_front();
          checkOutput("decoded_record",
                      {rd_sel, update_rd, imm32, alu_opc, branch_condition, alu_op1_ra, alu_op2_rb,
                       mem_load, mem_store, branch_ra, is_call, instr_class, pc_plus_4_out, ill_act},
                      monExp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_valid = 1'b0; instr = '0; pc_plus_4 = '0; flush = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_pc", pc_plus_4_out, 32'h4);
    checkOutput("reset_imm", imm32, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming: ADD r1,r2,r3 then BEQ with all-ones offset
    applyStimulus(32'h0000_0253, 32'h104, mk(3'd1, 1, 32'h0, 4'd0, 3'd0, 1, 1, 0, 0, 0, 0, 2'd0, 32'h104, 0), 0, w, r);
    checkOutput("latency_valid", out_valid, 1);
    applyStimulus(32'h68FF_FFFF, 32'h108, mk(3'd7, 0, 32'hFFFF_FFFC, 4'd0, 3'd2, 0, 0, 0, 0, 0, 0, 2'd1, 32'h108, 0), 0, w, r);
    checkOutput("throughput_waits", w, 1);

    // Load-use on ra, then on the store data register rb
    applyStimulus(32'h8000_00A8, 32'h10C, mk(3'd2, 0, 32'h0, 4'd0, 3'd0, 1, 0, 1, 0, 0, 0, 2'd2, 32'h10C, 0), 0, w, r);
    applyStimulus(32'h0000_0111, 32'h110, mk(3'd4, 1, 32'h0, 4'd0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 32'h110, 0), 0, w, r);
    checkOutput("loaduse_waits", w, 2);
    checkOutput("nostall_ready", r, 1);
    applyStimulus(32'h8000_0100, 32'h114, mk(3'd4, 0, 32'h0, 4'd0, 3'd0, 1, 0, 1, 0, 0, 0, 2'd2, 32'h114, 0), 0, w, r);
    applyStimulus(32'h9000_0014, 32'h118, mk(3'd0, 0, 32'h0, 4'd0, 3'd0, 1, 0, 0, 1, 0, 0, 2'd2, 32'h118, 0), 0, w, r);
    checkOutput("store_hazard_waits", w, 2);

    // Stall: MOVHI held while execute is not ready
    applyStimulus(32'h1848_D0C0, 32'h11C, mk(3'd3, 1, 32'h1234_0000, 4'd6, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 32'h11C, 0), 0, w, r);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000_0253; pc_plus_4 = 32'h120;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_imm", imm32, 32'h1234_0000);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("ra_sel_plain", ra_sel, 3'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(32'h0000_0253, 32'h120, mk(3'd1, 1, 32'h0, 4'd0, 3'd0, 1, 1, 0, 0, 0, 0, 2'd0, 32'h120, 0), 0, w, r);
    checkOutput("stall_resume_waits", w, 1);

    // Flush with a CALL arriving: nothing may come out
    applyStimulus(32'h4000_0010, 32'h124, '0, 1, w, r);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // RET reads the link register combinationally
    in_valid = 1'b1; instr = 32'h4400_0018; pc_plus_4 = 32'h128;
    #1;
    checkOutput("ret_ra_sel", ra_sel, 3'd6);
    checkOutput("ret_rb_sel", rb_sel, 3'd0);
    applyStimulus(32'h4400_0018, 32'h128, mk(3'd0, 0, 32'h60, 4'd0, 3'd7, 0, 0, 0, 0, 1, 0, 2'd1, 32'h128, 0), 0, w, r);

    // Undefined MISC opcode
    applyStimulus(32'hFC00_0040, 32'h12C, mk(3'd1, 0, 32'h0, 4'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd3, 32'h12C, ILL_EN), 0, w, r);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Asynchronous reset while a load is stalled in the output register
    applyStimulus(32'h8000_00A8, 32'h130, mk(3'd2, 0, 32'h0, 4'd0, 3'd0, 1, 0, 1, 0, 0, 0, 2'd2, 32'h130, 0), 0, w, r);
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("prereset_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", out_valid, 0);
    checkOutput("rst_async_pc", pc_plus_4_out, 32'h4);
    checkOutput("rst_async_load", mem_load, 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
